branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequences branch resolution in the execute stage. Accepts one conditional branch from decode and waits for its operand from forwarding/regfile.
//  Evaluates the condition against zero using one condcodes instance, then issues a one-cycle redirect + flush when the branch is taken.
//  Keeps saturating resolved/taken performance counters and a watchdog on operand arrival.
// PARAMETERS
//  CNT_W     16  width of perf counters br_count / taken_count
//  WAIT_MAX  15  max cycles in WAIT before abort (1..2^WAIT_W-1)
//  WAIT_W    4   width of watchdog counter
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  br_valid     in   1      decode presents a branch
//  br_cond      in   3      0 EQ,1 LT,2 GT,3 LE,4 GE,5 NE,6 ALWAYS,7 NEVER
//  br_target    in   32     taken target address
//  br_ready     out  1      branch accepted this cycle when br_valid & br_ready
//  opnd_valid   in   1      opnd carries the branch operand this cycle
//  opnd         in   32     signed operand compared to zero
//  ext_flush    in   1      pipeline-wide flush from a higher-priority source
//  stall        out  1      hold fetch/decode
//  redirect     out  1      one-cycle pulse: fetch must load redirect_pc
//  redirect_pc  out  32     valid when redirect=1, else holds its last value
//  flush        out  1      one-cycle pulse, kill younger instructions (== redirect)
//  resolved     out  1      one-cycle pulse per completed branch (taken or not)
//  taken        out  1      valid with resolved
//  timeout      out  1      one-cycle pulse when WAIT watchdog expires
//  br_count     out  CNT_W  resolved branches, saturating
//  taken_count  out  CNT_W  taken branches, saturating
// BEHAVIOUR
//  - Reset: state=IDLE; all pulses, redirect_pc, both counters and the watchdog are 0.
//  - Reset has priority over every other input.
//  - FSM has three states: IDLE, WAIT and RESOLVE.
//  - IDLE: br_ready = ~redirect & ~ext_flush. On accept, latch cond and target.
//    - If opnd_valid is also high that cycle, latch opnd and go to RESOLVE.
//    - Otherwise go to WAIT and clear the watchdog.
//  - WAIT: stall=1, br_ready=0. When opnd_valid, latch opnd and go to RESOLVE.
//    - Otherwise the watchdog increments. When it reaches WAIT_MAX, pulse timeout for 1 cycle and go to IDLE with no resolved pulse.
//  - RESOLVE: stall=1. Evaluate the latched cond on the latched opnd: EQ=zero, LT=~zero&neg, GT=~zero&~neg, LE=zero|neg, GE=zero|~neg, NE=~zero.
//    - Register the results, go to IDLE.
//    - Next cycle: resolved=1, taken=result, redirect=flush=result, redirect_pc=target.
//  - Latency: operand present at accept -> resolved is visible 2 cycles after the accept edge.
//    - Each WAIT cycle adds 1.
//  - stall is combinational from state (WAIT|RESOLVE) and is 0 in IDLE.
//  - Back-to-back: a branch may be accepted in the cycle resolved=1 only if redirect=0.
//  - ext_flush in any state: go to IDLE at the next edge, discarding the in-flight branch.
//    - No resolved, redirect or timeout pulse that edge; counters unchanged.
//    - Overrides a same-cycle accept or RESOLVE completion.
//  - Counters: br_count++ on each resolved pulse and taken_count++ on each taken pulse.
//    - Both saturate at all-ones; no wrap.
//  - br_cond 6/7 ignore the operand but still wait for opnd_valid (uniform timing).
// STRUCTURE
//  - Shared package holds: cond encodings (COND_EQ..COND_NEVER), FSM state localparams (2-bit), and the instruction-address width (32).
//  - One sub-module: the existing condcodes, instanced on the latched operand.
//    - A local 8:1 mux selects its flag by cond.
//  - Everything else (FSM, watchdog, counters) is flat in this module.
// TESTING
//  - Reset: hold rst 2 cycles mid-WAIT -> state IDLE, stall=0, counters 0, no pulses.
//  - BEQ, opnd=0 valid at accept, target=0x400 -> 2 cycles later redirect=flush=taken=1, redirect_pc=0x400, br_count=1.
//  - BLT, opnd=0x00000005 arriving 3 cycles late -> stall for 4 cycles, resolved=1 taken=0, no redirect; taken_count=0.
//  - BGE with opnd=0x80000000 -> not taken; BLE with the same operand -> taken. BNE with 0 -> not taken.
//  - WAIT_MAX=15, opnd_valid never asserted -> timeout pulse exactly 15 cycles after entering WAIT, back to IDLE, counters unchanged.
//  - ext_flush in RESOLVE, and br_count preloaded near all-ones -> no pulses after ext_flush; counter saturates at 0xFFFF.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the execute-stage branch resolution controller:
// condition encodings, FSM states and the instruction-address width.
package branch_resolve_ctrl_pkg;

  localparam int IADDR_W = 32;

  typedef enum logic [2:0] {
    COND_EQ     = 3'd0,
    COND_LT     = 3'd1,
    COND_GT     = 3'd2,
    COND_LE     = 3'd3,
    COND_GE     = 3'd4,
    COND_NE     = 3'd5,
    COND_ALWAYS = 3'd6,
    COND_NEVER  = 3'd7
  } cond_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;

endpackage

// File: rtl/branch_resolve_ctrl_condcodes.sv
// Signed compare-against-zero flags for a single operand.
module branch_resolve_ctrl_condcodes #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  output logic         eq,
  output logic         lt,
  output logic         gt,
  output logic         le,
  output logic         ge,
  output logic         ne
);

  logic zero;
  logic neg;

  assign zero = (value == '0);
  assign neg  = value[W-1];

  assign eq = zero;
  assign lt = ~zero & neg;
  assign gt = ~zero & ~neg;
  assign le = zero | neg;
  assign ge = zero | ~neg;
  assign ne = ~zero;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch resolution: accepts one branch, waits for its operand,
// evaluates the condition and emits redirect/flush plus perf counters.
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               br_valid,
  input  logic [2:0]         br_cond,
  input  logic [IADDR_W-1:0] br_target,
  output logic               br_ready,
  input  logic               opnd_valid,
  input  logic [31:0]        opnd,
  input  logic               ext_flush,
  output logic               stall,
  output logic               redirect,
  output logic [IADDR_W-1:0] redirect_pc,
  output logic               flush,
  output logic               resolved,
  output logic               taken,
  output logic               timeout,
  output logic [CNT_W-1:0]   br_count,
  output logic [CNT_W-1:0]   taken_count
);

  state_t               state;
  cond_t                cond_q;
  logic [IADDR_W-1:0]   target_q;
  logic [31:0]          opnd_q;
  logic [WAIT_W-1:0]    wd;

  logic f_eq, f_lt, f_gt, f_le, f_ge, f_ne;
  logic cond_hit;

  branch_resolve_ctrl_condcodes #(.W(32)) u_condcodes (
    .value (opnd_q),
    .eq    (f_eq),
    .lt    (f_lt),
    .gt    (f_gt),
    .le    (f_le),
    .ge    (f_ge),
    .ne    (f_ne)
  );

  always_comb begin
    cond_hit = 1'b0;
    case (cond_q)
      COND_EQ:     cond_hit = f_eq;
      COND_LT:     cond_hit = f_lt;
      COND_GT:     cond_hit = f_gt;
      COND_LE:     cond_hit = f_le;
      COND_GE:     cond_hit = f_ge;
      COND_NE:     cond_hit = f_ne;
      COND_ALWAYS: cond_hit = 1'b1;
      COND_NEVER:  cond_hit = 1'b0;
      default:     cond_hit = 1'b0;
    endcase
  end

  // A taken branch blocks acceptance for one cycle so fetch can take the redirect.
  assign br_ready = (state == ST_IDLE) & ~redirect & ~ext_flush;
  assign stall    = (state == ST_WAIT) | (state == ST_RESOLVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cond_q      <= COND_EQ;
      target_q    <= '0;
      opnd_q      <= '0;
      wd          <= '0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
      flush       <= 1'b0;
      resolved    <= 1'b0;
      taken       <= 1'b0;
      timeout     <= 1'b0;
      br_count    <= '0;
      taken_count <= '0;
    end else begin
      redirect <= 1'b0;
      flush    <= 1'b0;
      resolved <= 1'b0;
      taken    <= 1'b0;
      timeout  <= 1'b0;
      if (ext_flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (br_valid && br_ready) begin
              cond_q   <= cond_t'(br_cond);
              target_q <= br_target;
              if (opnd_valid) begin
                opnd_q <= opnd;
                state  <= ST_RESOLVE;
              end else begin
                wd    <= '0;
                state <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (opnd_valid) begin
              opnd_q <= opnd;
              state  <= ST_RESOLVE;
            end else if (wd == WAIT_W'(WAIT_MAX - 1)) begin
              wd      <= wd + 1'b1;
              timeout <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          ST_RESOLVE: begin
            resolved <= 1'b1;
            taken    <= cond_hit;
            redirect <= cond_hit;
            flush    <= cond_hit;
            if (cond_hit) begin
              redirect_pc <= target_q;
              if (taken_count != '1) taken_count <= taken_count + 1'b1;
            end
            if (br_count != '1) br_count <= br_count + 1'b1;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: directed branches push expected
// pulses; a negedge monitor pops and compares whenever the DUT pulses.
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  // Narrow counters so saturation is reachable with a handful of branches.
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 15;
  localparam int WAIT_W   = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              br_valid;
  logic [2:0]        br_cond;
  logic [31:0]       br_target;
  logic              br_ready;
  logic              opnd_valid;
  logic [31:0]       opnd;
  logic              ext_flush;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              flush;
  logic              resolved;
  logic              taken;
  logic              timeout;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  taken_count;

  branch_resolve_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX), .WAIT_W(WAIT_W)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
    .br_ready(br_ready), .opnd_valid(opnd_valid), .opnd(opnd), .ext_flush(ext_flush),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush),
    .resolved(resolved), .taken(taken), .timeout(timeout), .br_count(br_count),
    .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_timeout;
    bit          tk;
    logic [31:0] pc;
    int          at;
    int          bc;
    int          tc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          m_bc = 0;
  int          m_tc = 0;
  logic [31:0] m_pc = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(output bit ok);
    int n = 0;
    while (!br_ready && n < 4) begin
      tick();
      n++;
    end
    checkOutput("br_ready", br_ready, 1'b1);
    ok = br_ready;
  endtask

  // Issue one branch whose operand arrives 'late' cycles after acceptance.
  task automatic applyStimulus(input logic [2:0] cond, input logic [31:0] target,
                               input logic [31:0] op, input int late, input bit exp_tk);
    exp_t e;
    bit   ok;
    br_valid   = 1'b1;
    br_cond    = cond;
    br_target  = target;
    opnd_valid = (late == 0);
    opnd       = (late == 0) ? op : ~op;
    waitReady(ok);
    if (!ok) begin
      br_valid   = 1'b0;
      opnd_valid = 1'b0;
      return;
    end
    if (m_bc < CNT_MAX) m_bc++;
    if (exp_tk) begin
      if (m_tc < CNT_MAX) m_tc++;
      m_pc = target;
    end
    e.is_timeout = 1'b0;
    e.tk         = exp_tk;
    e.pc         = m_pc;
    e.at         = cyc + 2 + late;
    e.bc         = m_bc;
    e.tc         = m_tc;
    sb.push_back(e);
    tick();
    br_valid   = 1'b0;
    opnd_valid = 1'b0;
    for (int c = 1; c <= late; c++) begin
      opnd_valid = (c == late);
      opnd       = (c == late) ? op : ~op;
      checkOutput("stall_wait", stall, 1'b1);
      checkOutput("br_ready_wait", br_ready, 1'b0);
      tick();
    end
    opnd_valid = 1'b0;
    checkOutput("stall_resolve", stall, 1'b1);
    tick();
    checkOutput("stall_after_resolve", stall, 1'b0);
  endtask

  task automatic applyTimeout(input logic [31:0] target);
    exp_t e;
    bit   ok;
    br_valid   = 1'b1;
    br_cond    = COND_ALWAYS;
    br_target  = target;
    opnd_valid = 1'b0;
    waitReady(ok);
    if (!ok) begin
      br_valid = 1'b0;
      return;
    end
    e.is_timeout = 1'b1;
    e.tk         = 1'b0;
    e.pc         = m_pc;
    e.at         = cyc + 1 + WAIT_MAX;
    e.bc         = m_bc;
    e.tc         = m_tc;
    sb.push_back(e);
    tick();
    br_valid = 1'b0;
    for (int c = 0; c < WAIT_MAX; c++) begin
      checkOutput("stall_timeout_wait", stall, 1'b1);
      tick();
    end
    checkOutput("stall_after_timeout", stall, 1'b0);
  endtask

  // Monitor: every pulse must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (resolved || timeout || redirect || flush || taken)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pulse: got res=%0b to=%0b redir=%0b flush=%0b expected none at cycle %0d",
                   resolved, timeout, redirect, flush, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("pulse_cycle", cyc, e.at);
          checkOutput("resolved", resolved, !e.is_timeout);
          checkOutput("timeout", timeout, e.is_timeout);
          checkOutput("taken", taken, e.tk);
          checkOutput("redirect", redirect, e.tk);
          checkOutput("flush", flush, e.tk);
          checkOutput("redirect_pc", redirect_pc, e.pc);
          checkOutput("br_count", br_count, e.bc);
          checkOutput("taken_count", taken_count, e.tc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    rst = 1'b1; br_valid = 1'b0; br_cond = 3'd0; br_target = '0;
    opnd_valid = 1'b0; opnd = '0; ext_flush = 1'b0;
    tick(); tick(); tick();
    checkOutput("reset_stall", stall, 1'b0);
    checkOutput("reset_br_count", br_count, 0);
    checkOutput("reset_taken_count", taken_count, 0);
    checkOutput("reset_redirect_pc", redirect_pc, 0);
    checkOutput("reset_pulses", {redirect, flush, resolved, taken, timeout}, 0);
    rst = 1'b0;
    tick();

    applyStimulus(COND_EQ, 32'h0000_0400, 32'h0, 0, 1'b1);
    checkOutput("ready_blocked_by_redirect", br_ready, 1'b0);
    applyStimulus(COND_LT, 32'h0000_0444, 32'h0000_0005, 3, 1'b0);
    checkOutput("ready_back_to_back", br_ready, 1'b1);

    // Mid-WAIT reset held two cycles
    br_valid = 1'b1; br_cond = COND_LT; br_target = 32'h0000_0BAD; opnd_valid = 1'b0;
    tick();
    br_valid = 1'b0;
    tick();
    checkOutput("pre_reset_stall", stall, 1'b1);
    rst = 1'b1;
    tick(); tick();
    checkOutput("midwait_reset_stall", stall, 1'b0);
    checkOutput("midwait_reset_br_count", br_count, 0);
    checkOutput("midwait_reset_taken_count", taken_count, 0);
    checkOutput("midwait_reset_pc", redirect_pc, 0);
    checkOutput("midwait_reset_pulses", {redirect, flush, resolved, taken, timeout}, 0);
    rst = 1'b0;
    m_bc = 0; m_tc = 0; m_pc = '0;
    tick();

    applyStimulus(COND_GE, 32'h0000_0480, 32'h8000_0000, 0, 1'b0);
    applyStimulus(COND_LE, 32'h0000_0500, 32'h8000_0000, 0, 1'b1);
    applyStimulus(COND_NE, 32'h0000_0540, 32'h0000_0000, 0, 1'b0);
    applyStimulus(COND_GT, 32'h0000_0600, 32'h0000_0007, 1, 1'b1);
    applyStimulus(COND_LT, 32'h0000_0700, 32'hFFFF_FFFF, 2, 1'b1);
    applyStimulus(COND_EQ, 32'h0000_0740, 32'h0000_0001, 0, 1'b0);
    applyStimulus(COND_NE, 32'h0000_0800, 32'h0000_0010, 0, 1'b1);
    applyStimulus(COND_GE, 32'h0000_0900, 32'h0000_0000, 0, 1'b1);
    applyStimulus(COND_LE, 32'h0000_0940, 32'h0000_0001, 0, 1'b0);
    applyStimulus(COND_GT, 32'h0000_0980, 32'h0000_0000, 0, 1'b0);
    applyStimulus(COND_NEVER, 32'h0000_09C0, 32'h0000_0000, 1, 1'b0);
    applyStimulus(COND_ALWAYS, 32'h0000_0A00, 32'h8000_0000, 0, 1'b1);
    tick();

    applyTimeout(32'h0000_0C00);
    tick();

    // ext_flush in RESOLVE: the would-be-taken branch vanishes silently
    br_valid = 1'b1; br_cond = COND_EQ; br_target = 32'h0000_0D00; opnd = '0; opnd_valid = 1'b1;
    tick();
    br_valid = 1'b0; opnd_valid = 1'b0;
    ext_flush = 1'b1;
    checkOutput("flush_blocks_ready", br_ready, 1'b0);
    tick();
    ext_flush = 1'b0;
    checkOutput("flush_resolve_pulses", {redirect, flush, resolved, taken, timeout}, 0);
    checkOutput("flush_resolve_stall", stall, 1'b0);
    tick(); tick();

    // ext_flush in WAIT: a late operand afterwards must be ignored
    br_valid = 1'b1; br_cond = COND_ALWAYS; br_target = 32'h0000_0E00; opnd_valid = 1'b0;
    tick();
    br_valid = 1'b0;
    tick();
    ext_flush = 1'b1;
    tick();
    ext_flush = 1'b0;
    opnd_valid = 1'b1;
    checkOutput("flush_wait_stall", stall, 1'b0);
    tick();
    opnd_valid = 1'b0;
    tick(); tick();

    for (int i = 0; i < 10; i++)
      applyStimulus(COND_ALWAYS, 32'h0000_1000 + 32'(i * 4), 32'h0, i % 2, 1'b1);
    tick();
    checkOutput("br_count_saturated", br_count, CNT_MAX);
    checkOutput("taken_count_saturated", taken_count, CNT_MAX);

    // ext_flush in RESOLVE with saturated counters
    br_valid = 1'b1; br_cond = COND_ALWAYS; br_target = 32'h0000_2000; opnd_valid = 1'b1;
    tick();
    br_valid = 1'b0; opnd_valid = 1'b0; ext_flush = 1'b1;
    tick();
    ext_flush = 1'b0;
    tick(); tick();
    checkOutput("sat_flush_br_count", br_count, CNT_MAX);
    checkOutput("sat_flush_taken_count", taken_count, CNT_MAX);
    checkOutput("sat_flush_pc", redirect_pc, m_pc);

    tick(); tick();
    checkOutput("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
